// File: rtl/mas16b_prog_loader_if.sv
// Byte-stream handshake into the program loader: a byte moves on a cycle
// with byte_valid and byte_ready both high; the high byte of each word goes first.
interface mas16b_prog_loader_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;

  modport master (output byte_in, output byte_valid, input byte_ready);
  modport slave  (input byte_in, input byte_valid, output byte_ready);
endinterface

// File: rtl/mas16b_prog_loader.sv
// Buffers a byte-streamed program up to END_INSTR, then clocks it into the CPU program port.
// Outputs are registered (1 cycle behind the state decision); byte_ready is high only while receiving.
module mas16b_prog_loader #(
  parameter int          MAX_WORDS = 32,
  parameter logic [15:0] END_INSTR = 16'hF000
) (
  input  logic                       clk,
  input  logic                       rstz,
  input  logic                       start,
  mas16b_prog_loader_if.slave        bs,
  output logic [15:0]                pg_instr,
  output logic                       pg,
  output logic                       cpu_rstz,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [$clog2(MAX_WORDS):0] word_count
);

  localparam int AW = $clog2(MAX_WORDS);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {IDLE, RECV, PRE_RST, STREAM, POST_RST, DONE, ERR} state_t;

  state_t         state, nxt;
  logic           phase, phase_nxt;
  logic [7:0]     hi, hi_nxt;
  logic [CW-1:0]  rd_idx, rd_nxt;
  logic [CW-1:0]  wc_nxt;
  logic [15:0]    word;
  logic           wr_en;
  logic [AW-1:0]  rd_addr;
  logic [15:0]    instr_nxt;
  logic           pg_nxt, cpu_rstz_nxt, ready_nxt, busy_nxt, done_nxt, err_nxt;
  logic           byte_ready_q;
  logic [15:0]    buffer [MAX_WORDS];

  assign bs.byte_ready = byte_ready_q;
  assign word          = {hi, bs.byte_in};
  assign rd_addr       = (state == STREAM) ? rd_idx[AW-1:0] : '0;

  always_comb begin
    nxt       = state;
    phase_nxt = phase;
    hi_nxt    = hi;
    rd_nxt    = rd_idx;
    wc_nxt    = word_count;
    wr_en     = 1'b0;
    case (state)
      IDLE, DONE, ERR: begin
        if (start) begin
          nxt       = RECV;
          wc_nxt    = '0;
          phase_nxt = 1'b0;
        end
      end
      RECV: begin
        if (bs.byte_valid && byte_ready_q) begin
          if (!phase) begin
            hi_nxt    = bs.byte_in;
            phase_nxt = 1'b1;
          end else begin
            phase_nxt = 1'b0;
            // The end marker always fits: overflow is only declared for non-marker words.
            if (word == END_INSTR) begin
              wr_en  = 1'b1;
              wc_nxt = word_count + CW'(1);
              nxt    = PRE_RST;
            end else if (word_count == CW'(MAX_WORDS - 1)) begin
              nxt = ERR;
            end else begin
              wr_en  = 1'b1;
              wc_nxt = word_count + CW'(1);
            end
          end
        end
      end
      PRE_RST: begin
        nxt    = STREAM;
        rd_nxt = CW'(1);
      end
      STREAM: begin
        if (rd_idx == word_count) nxt = POST_RST;
        else                      rd_nxt = rd_idx + CW'(1);
      end
      POST_RST: nxt = DONE;
      default:  nxt = IDLE;
    endcase

    // Outputs are decoded from the next state so they appear on the entering edge.
    instr_nxt    = (nxt == STREAM) ? buffer[rd_addr] : 16'h0000;
    pg_nxt       = !(nxt == POST_RST || nxt == DONE);
    cpu_rstz_nxt = (nxt == STREAM) || (nxt == DONE);
    ready_nxt    = (nxt == RECV);
    busy_nxt     = (nxt == RECV) || (nxt == PRE_RST) || (nxt == STREAM) || (nxt == POST_RST);
    done_nxt     = (nxt == DONE);
    err_nxt      = (nxt == ERR);
  end

  always_ff @(posedge clk or posedge rstz) begin
    if (rstz) begin
      state        <= IDLE;
      phase        <= 1'b0;
      hi           <= 8'h00;
      rd_idx       <= '0;
      word_count   <= '0;
      pg_instr     <= 16'h0000;
      pg           <= 1'b1;
      cpu_rstz     <= 1'b0;
      byte_ready_q <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      state        <= nxt;
      phase        <= phase_nxt;
      hi           <= hi_nxt;
      rd_idx       <= rd_nxt;
      word_count   <= wc_nxt;
      pg_instr     <= instr_nxt;
      pg           <= pg_nxt;
      cpu_rstz     <= cpu_rstz_nxt;
      byte_ready_q <= ready_nxt;
      busy         <= busy_nxt;
      done         <= done_nxt;
      err          <= err_nxt;
    end
  end

  // Program memory keeps its contents across reset and restart; word_count marks what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) buffer[word_count[AW-1:0]] <= word;
  end

endmodule

// File: tb/tb_mas16b_prog_loader.sv
// Directed bench for mas16b_prog_loader: load, handshake gaps, overflow, boundary, reset and restart.
module tb_mas16b_prog_loader;

  logic        clk;
  logic        rstz;
  logic        start;
  logic [15:0] pg_instr;
  logic        pg, cpu_rstz, busy, done, err;
  logic [5:0]  word_count;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];

  mas16b_prog_loader_if bs();

  mas16b_prog_loader #(.MAX_WORDS(32), .END_INSTR(16'hF000)) dut (
    .clk(clk), .rstz(rstz), .start(start), .bs(bs.slave),
    .pg_instr(pg_instr), .pg(pg), .cpu_rstz(cpu_rstz), .busy(busy),
    .done(done), .err(err), .word_count(word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int   n;
    logic rdy;
    bs.byte_in    = b;
    bs.byte_valid = 1'b1;
    n = 0;
    do begin
      rdy = bs.byte_ready;
      tick();
      n++;
    end while (!rdy && n < 20);
    bs.byte_valid = 1'b0;
    check("byte_accept", {31'd0, rdy}, 32'd1);
    if (gap) tick();
  endtask

  task automatic send_word(input logic [15:0] w, input bit gap);
    send_byte(w[15:8], gap);
    send_byte(w[7:0], gap);
  endtask

  // Called right after the edge that stored the end marker: walks PRE_RST, STREAM, POST_RST, DONE.
  task automatic expect_program();
    check("pre_pg", {31'd0, pg}, 32'd1);
    check("pre_cpu_rstz", {31'd0, cpu_rstz}, 32'd0);
    check("pre_instr", {16'd0, pg_instr}, 32'd0);
    check("pre_ready", {31'd0, bs.byte_ready}, 32'd0);
    for (int i = 0; i < exp_q.size(); i++) begin
      tick();
      check($sformatf("stream_instr[%0d]", i), {16'd0, pg_instr}, {16'd0, exp_q[i]});
      check($sformatf("stream_ctl[%0d]", i), {30'd0, pg, cpu_rstz}, 32'd3);
    end
    tick();
    check("post_ctl", {30'd0, pg, cpu_rstz}, 32'd0);
    check("post_instr", {16'd0, pg_instr}, 32'd0);
    tick();
    check("done_ctl", {30'd0, pg, cpu_rstz}, 32'd1);
    check("done_flag", {29'd0, done, busy, err}, 32'd4);
    check("done_count", {26'd0, word_count}, exp_q.size());
  endtask

  initial begin
    rstz          = 1'b1;
    start         = 1'b0;
    bs.byte_in    = 8'h00;
    bs.byte_valid = 1'b0;
    #1;
    check("rst_pg", {31'd0, pg}, 32'd1);
    check("rst_cpu_rstz", {31'd0, cpu_rstz}, 32'd0);
    check("rst_instr", {16'd0, pg_instr}, 32'd0);
    check("rst_flags", {28'd0, bs.byte_ready, busy, done, err}, 32'd0);
    check("rst_count", {26'd0, word_count}, 32'd0);
    tick();
    tick();
    rstz = 1'b0;
    tick();

    // Basic load
    pulse_start();
    check("recv_ready", {31'd0, bs.byte_ready}, 32'd1);
    check("recv_busy", {31'd0, busy}, 32'd1);
    send_byte(8'hA0, 0); send_byte(8'h01, 0);
    send_byte(8'hA0, 0); send_byte(8'h02, 0);
    send_byte(8'hF0, 0); send_byte(8'h00, 0);
    exp_q = '{16'hA001, 16'hA002, 16'hF000};
    expect_program();

    // Restart from DONE with gapped bytes; start inside RECV must not disturb anything
    pulse_start();
    check("restart_count", {26'd0, word_count}, 32'd0);
    check("restart_ctl", {30'd0, pg, cpu_rstz}, 32'd2);
    check("restart_done", {31'd0, done}, 32'd0);
    send_word(16'hA001, 1);
    check("count_1", {26'd0, word_count}, 32'd1);
    pulse_start();
    check("ignored_start_count", {26'd0, word_count}, 32'd1);
    check("ignored_start_ready", {31'd0, bs.byte_ready}, 32'd1);
    send_byte(8'hA0, 1);
    pulse_start();
    send_byte(8'h02, 1);
    send_byte(8'hF0, 1);
    send_byte(8'h00, 0);
    expect_program();

    // Overflow: 31 ordinary words then one more ordinary word
    pulse_start();
    for (int i = 0; i < 31; i++) send_word(16'h0100 + 16'(i), 0);
    check("ovf_count_pre", {26'd0, word_count}, 32'd31);
    send_word(16'h1234, 0);
    check("ovf_err", {29'd0, done, busy, err}, 32'd1);
    check("ovf_count", {26'd0, word_count}, 32'd31);
    check("ovf_ctl", {30'd0, pg, cpu_rstz}, 32'd2);
    tick(); tick(); tick();
    check("ovf_hold_ctl", {30'd0, pg, cpu_rstz}, 32'd2);
    check("ovf_hold_instr", {16'd0, pg_instr}, 32'd0);

    // Boundary: 31 ordinary words then the marker fills the buffer exactly
    pulse_start();
    check("err_restart", {31'd0, err}, 32'd0);
    exp_q = {};
    for (int i = 0; i < 31; i++) begin
      send_word(16'h0200 + 16'(i), 0);
      exp_q.push_back(16'h0200 + 16'(i));
    end
    send_word(16'hF000, 0);
    exp_q.push_back(16'hF000);
    check("bnd_count", {26'd0, word_count}, 32'd32);
    expect_program();

    // Reset in the middle of streaming
    pulse_start();
    send_word(16'h1111, 0);
    send_word(16'h2222, 0);
    send_word(16'hF000, 0);
    tick();
    check("mid_instr0", {16'd0, pg_instr}, 32'h1111);
    tick();
    check("mid_instr1", {16'd0, pg_instr}, 32'h2222);
    rstz = 1'b1;
    #1;
    check("mid_rst_ctl", {30'd0, pg, cpu_rstz}, 32'd2);
    check("mid_rst_instr", {16'd0, pg_instr}, 32'd0);
    check("mid_rst_flags", {28'd0, bs.byte_ready, busy, done, err}, 32'd0);
    check("mid_rst_count", {26'd0, word_count}, 32'd0);
    tick();
    rstz = 1'b0;
    tick();
    check("mid_idle_busy", {31'd0, busy}, 32'd0);
    pulse_start();
    send_word(16'hF000, 0);
    exp_q = '{16'hF000};
    expect_program();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mas16b_prog_loader.md
MAS16B_PROG_LOADER -- requirements
Module: mas16b_prog_loader

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 32, meaning program buffer depth in 16-bit words, including the end marker.
REQ-002 SHALL have parameter END_INSTR, default 16'hF000, meaning the end-of-program instruction.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rstz  input  1  asynchronous, active-high reset (asserted = 1).
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins a new program load.
REQ-006 SHALL have port byte_in  input  8  program byte stream, high byte of each word first.
REQ-007 SHALL have port byte_valid  input  1  byte_in holds a valid byte.
REQ-008 SHALL have port byte_ready  output  1  loader accepts a byte this cycle.
REQ-009 SHALL have port pg_instr  output  16  instruction word driven to the CPU program port.
REQ-010 SHALL have port pg  output  1  CPU program-mode select (1 = program, 0 = run).
REQ-011 SHALL have port cpu_rstz  output  1  active-low reset to the CPU.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE, DONE and ERR.
REQ-013 SHALL have port done  output  1  high in DONE.
REQ-014 SHALL have port err  output  1  high in ERR.
REQ-015 SHALL have port word_count  output  clog2(MAX_WORDS)+1  number of words buffered in the current load.

Function
REQ-016 SHALL implement states IDLE, RECV, PRE_RST, STREAM, POST_RST, DONE, ERR.
REQ-017 SHALL accept a byte only on a cycle with byte_valid=1 and byte_ready=1.
REQ-018 SHALL drive byte_ready=1 only in RECV.
REQ-019 SHALL transition IDLE/DONE/ERR -> RECV on start=1, clearing word_count and the byte phase.
REQ-020 SHALL ignore start in RECV, PRE_RST, STREAM and POST_RST.
REQ-021 SHALL, in RECV, hold an accepted high byte and complete a word on the next accepted byte: word = {high, low}.
REQ-022 SHALL, on each completed word, write it to buffer[word_count] and increment word_count in the same edge.
REQ-023 SHALL go RECV -> PRE_RST on the edge that stores a word equal to END_INSTR; the marker is stored and counted.
REQ-024 SHALL go RECV -> ERR, without storing, when a completed word is not END_INSTR and word_count == MAX_WORDS-1.
REQ-025 SHALL spend exactly 1 cycle in PRE_RST with pg=1, cpu_rstz=0, pg_instr=0.
REQ-026 SHALL, in STREAM, present buffer[0] .. buffer[word_count-1] on pg_instr on consecutive cycles, one word per cycle, no gaps, with pg=1 and cpu_rstz=1.
REQ-027 SHALL go STREAM -> POST_RST after the cycle presenting buffer[word_count-1], so STREAM lasts exactly word_count cycles.
REQ-028 SHALL spend exactly 1 cycle in POST_RST with pg=0, cpu_rstz=0, pg_instr=0.
REQ-029 SHALL, in DONE, drive pg=0, cpu_rstz=1, pg_instr=0, leaving the CPU running.
REQ-030 SHALL, in IDLE, RECV and ERR, drive pg=1, cpu_rstz=0, pg_instr=0, holding the CPU in reset.
REQ-031 SHALL register all outputs; the CPU sees each state's outputs from the edge that enters that state.
REQ-032 SHALL leave buffer contents unchanged by reset or start; only word_count defines valid data.

Reset
REQ-033 SHALL, while rstz=1, asynchronously force: state IDLE, pg=1, cpu_rstz=0, pg_instr=16'h0000, byte_ready=0, busy=0, done=0, err=0, word_count=0, byte phase = high.
REQ-034 SHALL return to IDLE from any state when rstz asserts mid-load or mid-stream; a partially received word is discarded.

Verification
REQ-035 Reset and program: start, bytes A0 01 A0 02 F0 00 -> PRE_RST 1 cycle (pg=1, cpu_rstz=0); pg_instr = A001, A002, F000 on 3 consecutive cycles; POST_RST 1 cycle (pg=0, cpu_rstz=0); DONE with pg=0, cpu_rstz=1, done=1, word_count=3.
REQ-036 Handshake: byte_valid toggling 1/0 every cycle during RECV -> identical pg_instr sequence; no byte is dropped or duplicated.
REQ-037 Overflow: MAX_WORDS=32, 31 non-end words then 16'h1234 -> ERR, err=1, word_count=31, pg=1, cpu_rstz=0, no STREAM cycles.
REQ-038 Boundary: 31 words then F000 -> STREAM exactly 32 cycles; the last pg_instr is F000.
REQ-039 Mid-stream reset: rstz=1 during STREAM -> same cycle pg=1, cpu_rstz=0, pg_instr=0, state IDLE; after release, start and a reload of F000 alone -> 1-cycle STREAM, then DONE.
REQ-040 Restart from DONE: start pulse in DONE -> RECV, word_count=0, cpu_rstz=0, pg=1; start during RECV is ignored.
